// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: async assert, DEPTH-flop sync release, HOLD stretch, then ack-gated staggered per-channel release.
// Latency: ch0 releases DEPTH+HOLD_CYCLES edges after dst_rst falls; each later channel follows its predecessor's accept by STAGGER+1 edges.
// Backpressure: none; a missing ch_ack is tolerated for ACK_TIMEOUT edges, then flagged. Optional RST_SEQ_SW_RST_EN adds sw_rst_req re-sequencing.
module rst_seq #(
  parameter int DEPTH       = 2,
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              dst_clk,
  input  logic              dst_rst,
`ifdef RST_SEQ_SW_RST_EN
  input  logic              sw_rst_req,
`endif
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_done,
  output logic              timeout_err
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int MAX_CNT = (MAX_HS > ACK_TIMEOUT) ? MAX_HS : ACK_TIMEOUT;
  localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    HOLD = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]  idx_q, idx_d, rel_idx;
  logic [NUM_CH-1:0] rst_n_d;
  logic              done_d, err_d;
  logic              rel, acc;
  logic              sync_out;

  assign sync_out = sync_q[DEPTH-1];
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // The chain is never cleared by a software request: only dst_rst restarts synchronisation.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      idx_q       <= '0;
      ch_rst_n    <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ch_rst_n    <= rst_n_d;
      seq_done    <= done_d;
      timeout_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = ch_rst_n;
    done_d  = seq_done;
    err_d   = timeout_err;
    rel     = 1'b0;
    rel_idx = '0;
    acc     = 1'b0;

    case (state_q)
      SYNC: begin
        // Leave on the edge where the chain output itself goes high.
        if (sync_q[DEPTH-2]) begin
          cnt_d = '0;
          if (HOLD_CYCLES == 0) begin
            rel = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sync_out) begin
          if (int'(cnt_q) + 1 >= HOLD_CYCLES) begin
            rel = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT: begin
        if (ACK_TIMEOUT == 0 || ch_ack[idx_q]) begin
          acc = 1'b1;
        end else if (int'(cnt_q) + 1 >= ACK_TIMEOUT) begin
          acc   = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(STAGGER)) begin
          rel     = 1'b1;
          rel_idx = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // Release of a channel; with no ack wait the release edge is also its accept edge.
    if (rel) begin
      rst_n_d[rel_idx] = 1'b1;
      idx_d            = rel_idx;
      cnt_d            = '0;
      state_d          = WAIT;
      if (ACK_TIMEOUT == 0) begin
        acc = 1'b1;
      end
    end

    if (acc) begin
      cnt_d = '0;
      if (idx_d == IDX_W'(NUM_CH - 1)) begin
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        state_d = GAP;
      end
    end

`ifdef RST_SEQ_SW_RST_EN
    // Software re-sequence restarts from the stretch, keeping the hardware sync result.
    if (sw_rst_req && state_q != SYNC) begin
      rst_n_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = HOLD;
    end
`endif
  end

endmodule
